// File: rtl/crono_pkg.sv
// ============================================================================
// Module      : crono_pkg
// Description : Shared types and constants for the stopwatch controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package crono_pkg;

    localparam int DIGITS_W = 24;
    localparam logic [DIGITS_W-1:0] ALL_NINES = 24'h999999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } crono_state_t;

    // The prescaler and tick logic are live in both RUN and LAP.
    function automatic logic is_counting(input crono_state_t s);
        return (s == RUN) || (s == LAP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/crono_btn_cond.sv
// ============================================================================
// Module      : crono_btn_cond
// Description : 2-flop synchronizer, stability debounce and rising-edge pulse
//               for one raw push-button (used when CRONO_DEBOUNCE_EN is set).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crono_btn_cond #(
    parameter int DEB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic req
);

    localparam int c_cnt_w = $clog2(DEB_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEB_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    logic [1:0]         r_sync;
    logic               r_level;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_req;

    // r_cnt counts consecutive cycles the synchronized input differs from the
    // accepted level; only a full run of DEB_CYCLES flips the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_req   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], btn_raw};
            r_req  <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
                r_req   <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    assign req = r_req;

endmodule

`default_nettype wire

// File: rtl/crono_ctrl.sv
// ============================================================================
// Module      : crono_ctrl
// Description : Stopwatch run/stop/lap/clear sequencer with tick prescaler,
//               lap display freeze and all-nines overflow stop.
//               Optional macro CRONO_DEBOUNCE_EN adds button conditioning.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crono_ctrl
    import crono_pkg::*;
#(
    parameter int TICK_DIV   = 500000,
    parameter int DEB_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_ss,
    input  logic                btn_lap,
    input  logic                btn_clr,
    input  logic [DIGITS_W-1:0] digits_in,
    output logic                cnt_enable,
    output logic                cnt_clear,
    output logic [DIGITS_W-1:0] disp,
    output logic                running,
    output logic                lap_active,
    output logic                ovf
);

    localparam int c_pre_w = $clog2(TICK_DIV);
    localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(TICK_DIV - 1);
    localparam logic [c_pre_w-1:0] c_pre_one = c_pre_w'(1);

    // Request bit order: [2]=clr, [1]=ss, [0]=lap.
    logic [2:0] w_btn_raw;
    logic [2:0] w_req;

    assign w_btn_raw = {btn_clr, btn_ss, btn_lap};

`ifdef CRONO_DEBOUNCE_EN
    for (genvar i = 0; i < 3; i++) begin : g_btn
        crono_btn_cond #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_cond (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (w_btn_raw[i]),
            .req     (w_req[i])
        );
    end
`else
    // An illegal DEB_CYCLES leaves the requests undriven so lint catches it.
    if (DEB_CYCLES >= 1) begin : g_btn_direct
        assign w_req = w_btn_raw;
    end
`endif

    crono_state_t        r_state;
    crono_state_t        w_next;
    logic [c_pre_w-1:0]  r_pre;
    logic [c_pre_w-1:0]  w_pre_next;
    logic                r_cnt_enable;
    logic                r_cnt_clear;
    logic [DIGITS_W-1:0] r_disp;
    logic                r_ovf;

    logic w_counting;
    logic w_tick_pt;
    logic w_ovf_hit;
    logic w_tick;
    logic w_clear;
    logic w_set_ovf;
    logic w_clr_ovf;
    logic w_pre_rst;
    logic w_hold_disp;

    always_comb begin
        w_next      = r_state;
        w_clear     = 1'b0;
        w_set_ovf   = 1'b0;
        w_clr_ovf   = 1'b0;
        w_pre_rst   = 1'b0;
        w_counting  = is_counting(r_state);
        w_tick_pt   = w_counting && (r_pre == c_pre_max);
        w_ovf_hit   = w_tick_pt && (digits_in == ALL_NINES);
        w_tick      = w_tick_pt && !w_ovf_hit;

        case (r_state)
            IDLE: begin
                if (w_req[2]) begin
                    w_clear = 1'b1;
                end else if (w_req[1]) begin
                    w_next    = RUN;
                    w_pre_rst = 1'b1;
                end
            end
            RUN: begin
                if (w_ovf_hit) begin
                    w_next    = PAUSE;
                    w_set_ovf = 1'b1;
                end else if (w_req[1]) begin
                    w_next = PAUSE;
                end else if (w_req[0]) begin
                    w_next = LAP;
                end
            end
            LAP: begin
                if (w_ovf_hit) begin
                    w_next    = PAUSE;
                    w_set_ovf = 1'b1;
                end else if (w_req[1]) begin
                    w_next = PAUSE;
                end else if (w_req[0]) begin
                    w_next = RUN;
                end
            end
            PAUSE: begin
                if (w_req[2]) begin
                    w_next    = IDLE;
                    w_clear   = 1'b1;
                    w_clr_ovf = 1'b1;
                    w_pre_rst = 1'b1;
                end else if (w_req[1] && !r_ovf) begin
                    w_next = RUN;
                end
            end
            default: w_next = IDLE;
        endcase

        // A consumed tick always wraps; otherwise the count only advances while
        // staying in a counting state, so a pause keeps the partial period.
        w_pre_next = r_pre;
        if (w_pre_rst) begin
            w_pre_next = '0;
        end else if (w_tick_pt) begin
            w_pre_next = '0;
        end else if (w_counting && is_counting(w_next)) begin
            w_pre_next = r_pre + c_pre_one;
        end

        w_hold_disp = (r_state == LAP) && (w_next == LAP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pre        <= '0;
            r_cnt_enable <= 1'b0;
            r_cnt_clear  <= 1'b0;
            r_disp       <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_pre        <= w_pre_next;
            r_cnt_enable <= w_tick;
            r_cnt_clear  <= w_clear;
            if (!w_hold_disp) begin
                r_disp <= digits_in;
            end
            if (w_set_ovf) begin
                r_ovf <= 1'b1;
            end else if (w_clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign cnt_enable = r_cnt_enable;
    assign cnt_clear  = r_cnt_clear;
    assign disp       = r_disp;
    assign running    = is_counting(r_state);
    assign lap_active = (r_state == LAP);
    assign ovf        = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_crono_ctrl.sv
// ============================================================================
// Module      : tb_crono_ctrl
// Description : Directed self-checking bench for crono_ctrl, TICK_DIV=4,
//               DEB_CYCLES=3 (debounce steps run when CRONO_DEBOUNCE_EN is set).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crono_ctrl;

    logic        clk;
    logic        rst;
    logic        btn_ss;
    logic        btn_lap;
    logic        btn_clr;
    logic [23:0] digits_in;
    logic        cnt_enable;
    logic        cnt_clear;
    logic [23:0] disp;
    logic        running;
    logic        lap_active;
    logic        ovf;

    int n_pass  = 0;
    int n_total = 0;

    crono_ctrl #(
        .TICK_DIV   (4),
        .DEB_CYCLES (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_ss     (btn_ss),
        .btn_lap    (btn_lap),
        .btn_clr    (btn_clr),
        .digits_in  (digits_in),
        .cnt_enable (cnt_enable),
        .cnt_clear  (cnt_clear),
        .disp       (disp),
        .running    (running),
        .lap_active (lap_active),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;
        digits_in = 24'h000042;
        nc(); nc();
        chk("rst_enable", 32'(cnt_enable), 32'd0);
        chk("rst_clear",  32'(cnt_clear),  32'd0);
        chk("rst_disp",   32'(disp),       32'd0);
        chk("rst_running", 32'(running),   32'd0);
        chk("rst_lap",    32'(lap_active), 32'd0);
        chk("rst_ovf",    32'(ovf),        32'd0);
        rst = 1'b0;

`ifdef CRONO_DEBOUNCE_EN
        // 2-cycle glitch must be rejected
        btn_ss = 1'b1; nc(); nc(); btn_ss = 1'b0;
        repeat (10) nc();
        chk("deb_glitch", 32'(running), 32'd0);
        // held press: exactly one start, no repeat
        btn_ss = 1'b1;
        repeat (20) nc();
        chk("deb_press", 32'(running), 32'd1);
        btn_ss = 1'b0;
        repeat (10) nc();
        chk("deb_release", 32'(running), 32'd1);
        chk("deb_no_lap", 32'(lap_active), 32'd0);
        btn_lap = 1'b1; repeat (3) nc(); btn_lap = 1'b0;
        repeat (10) nc();
        chk("deb_lap3", 32'(lap_active), 32'd1);
`else
        // start: ticks every 4 cycles, first 4 cycles after accept
        btn_ss = 1'b1; nc(); btn_ss = 1'b0;
        chk("run_entry",   32'(running),    32'd1);
        chk("run_no_lap",  32'(lap_active), 32'd0);
        chk("disp_follow", 32'(disp),       32'h42);
        chk("run_no_tick0", 32'(cnt_enable), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            nc();
            chk("tick_seq", 32'(cnt_enable), (k % 4 == 0) ? 32'd1 : 32'd0);
        end

        // pause with pre=2, then resume: tick after 2 more cycles
        nc(); nc();
        btn_ss = 1'b1; nc(); btn_ss = 1'b0;
        chk("pause_state", 32'(running), 32'd0);
        for (int k = 0; k < 3; k++) begin
            nc();
            chk("pause_no_tick", 32'(cnt_enable), 32'd0);
        end
        btn_ss = 1'b1; nc(); btn_ss = 1'b0;
        chk("resume_state", 32'(running),    32'd1);
        chk("resume_r0",    32'(cnt_enable), 32'd0);
        nc(); chk("resume_r1", 32'(cnt_enable), 32'd0);
        nc(); chk("resume_r2", 32'(cnt_enable), 32'd1);

        // lap freeze while the counter keeps ticking
        digits_in = 24'h000123; btn_lap = 1'b1; nc(); btn_lap = 1'b0;
        digits_in = 24'h000124;
        chk("lap_active",  32'(lap_active), 32'd1);
        chk("lap_running", 32'(running),    32'd1);
        chk("lap_capture", 32'(disp),       32'h123);
        nc(); digits_in = 24'h000125;
        chk("lap_hold1", 32'(disp), 32'h123);
        nc(); chk("lap_hold2", 32'(disp), 32'h123);
        nc(); chk("lap_tick", 32'(cnt_enable), 32'd1);
        chk("lap_hold3", 32'(disp), 32'h123);
        btn_lap = 1'b1; nc(); btn_lap = 1'b0;
        chk("unlap_state", 32'(lap_active), 32'd0);
        chk("unlap_disp",  32'(disp),       32'h125);
        digits_in = 24'h000126;
        nc(); chk("unlap_track", 32'(disp), 32'h126);

        // clr ignored in RUN; ss coinciding with a tick still ticks
        btn_clr = 1'b1; nc(); btn_clr = 1'b0;
        chk("run_clr_ignored", 32'(cnt_clear), 32'd0);
        chk("run_clr_state",   32'(running),   32'd1);
        btn_ss = 1'b1; nc(); btn_ss = 1'b0;
        chk("ss_with_tick", 32'(cnt_enable), 32'd1);
        chk("ss_tick_pause", 32'(running),   32'd0);

        // PAUSE: clr beats ss
        btn_clr = 1'b1; btn_ss = 1'b1; nc(); btn_clr = 1'b0; btn_ss = 1'b0;
        chk("pclr_pulse",   32'(cnt_clear), 32'd1);
        chk("pclr_idle",    32'(running),   32'd0);
        chk("pclr_disp",    32'(disp),      32'h126);
        digits_in = 24'h000000;
        nc();
        chk("pclr_one_cyc", 32'(cnt_clear), 32'd0);
        chk("idle_disp",    32'(disp),      32'd0);

        // overflow at all nines
        btn_ss = 1'b1; nc(); btn_ss = 1'b0;
        digits_in = 24'h999999;
        nc(); nc(); nc();
        nc();
        chk("ovf_no_tick", 32'(cnt_enable), 32'd0);
        chk("ovf_pause",   32'(running),    32'd0);
        chk("ovf_set",     32'(ovf),        32'd1);
        btn_ss = 1'b1; nc(); btn_ss = 1'b0;
        chk("ovf_ss_ignored", 32'(running), 32'd0);
        chk("ovf_sticky",     32'(ovf),     32'd1);
        btn_clr = 1'b1; nc(); btn_clr = 1'b0;
        chk("ovf_clr_flag",  32'(ovf),       32'd0);
        chk("ovf_clr_pulse", 32'(cnt_clear), 32'd1);
        chk("ovf_clr_idle",  32'(running),   32'd0);

        // reset mid-run with a tick pending
        digits_in = 24'h000000;
        btn_ss = 1'b1; nc(); btn_ss = 1'b0;
        nc(); nc(); nc();
        rst = 1'b1; nc(); rst = 1'b0;
        chk("rst_run_tick",  32'(cnt_enable), 32'd0);
        chk("rst_run_state", 32'(running),    32'd0);
        nc();
        chk("rst_no_pending", 32'(cnt_enable), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
